serial_mux_sequencer: RTL
=========================

SERIAL_MUX_SEQUENCER -- requirements
Module: serial_mux_sequencer

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 0: 0 = bit order 0..7, 1 = bit order 7..0.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset, synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, 8, the parallel byte to serialize.
REQ-005 The block SHALL have port in_valid, input, 1, meaning in_data is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-007 The block SHALL have port a, output, 8, the registered byte under serialization, which drives the 8:1 mux data input.
REQ-008 The block SHALL have port s, output, 3, the registered select, which drives the 8:1 mux select input.
REQ-009 The block SHALL have port out_bit, output, 1, equal to a[s], the serial bit.
REQ-010 The block SHALL have port out_valid, output, 1, meaning out_bit is valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer takes out_bit this cycle.
REQ-012 The block SHALL have port out_last, output, 1, meaning the current bit is the final bit of the byte.
REQ-013 The block SHALL have port frame_cnt, output, 8, the count of completed bytes.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE and SHIFT.
REQ-015 Index constants SHALL be START = 0 and END = 7 when MSB_FIRST = 0, and START = 7 and END = 0 when MSB_FIRST = 1.
REQ-016 Input acceptance SHALL be defined as in_valid & in_ready.
REQ-017 Output acceptance SHALL be defined as out_valid & out_ready.
REQ-018 In IDLE: out_valid = 0 and in_ready = 1 (when rst is low); on acceptance, a <= in_data, s <= START, next state SHIFT.
REQ-019 In SHIFT: out_valid = 1 and out_bit = a[s], combinational from registered a and s, with no other logic in the path.
REQ-020 In SHIFT, on output acceptance with s != END, s SHALL step +1 (MSB_FIRST = 0) or -1 (MSB_FIRST = 1).
REQ-021 In SHIFT with out_ready low, a, s and state SHALL hold unchanged, for any number of cycles.
REQ-022 out_last SHALL equal out_valid & (s == END).
REQ-023 in_ready SHALL be 1 in IDLE, or in SHIFT when out_last & out_ready; otherwise 0.
REQ-024 On output acceptance of the END bit: frame_cnt SHALL increment; if input acceptance occurs in the same cycle, then a <= in_data, s <= START and state stays SHIFT (zero-bubble back-to-back); else state SHALL return to IDLE.
REQ-025 frame_cnt SHALL wrap from 255 to 0 with no flag.
REQ-026 Latency: the first bit SHALL be valid the cycle after input acceptance, and a byte SHALL take exactly 8 cycles with out_ready held high.
REQ-027 in_data SHALL be sampled only on input acceptance; in_data changes at any other time SHALL have no effect.
REQ-028 a and s SHALL be held unchanged in IDLE.

Reset
REQ-029 While rst = 1 at a clock edge, the block SHALL set state = IDLE, a = 8'h00, s = START, frame_cnt = 0.
REQ-030 While rst = 1, outputs SHALL be in_ready = 0, out_valid = 0, out_last = 0.
REQ-031 Reset mid-byte SHALL abort the byte without asserting out_last and without incrementing frame_cnt.
REQ-032 in_ready SHALL be 1 in the first cycle after rst falls.
REQ-033 rst SHALL take priority over all simultaneous handshakes.

Verification
REQ-034 MSB_FIRST=0, in_data=8'b11001100, out_ready=1 -> s=0..7 over 8 cycles; out_bit=0,0,1,1,0,0,1,1; out_last only on 8th; frame_cnt=1.
REQ-035 MSB_FIRST=1, same byte -> s=7..0; out_bit=1,1,0,0,1,1,0,0; out_last when s=0.
REQ-036 8'hA5 then 8'h3C, in_valid held high -> 16 contiguous valid cycles with no bubble; in_ready high only in the cycle of the first byte's last bit; a=8'h3C from the 9th bit.
REQ-037 out_ready low for 3 cycles at s=3 -> s, a, out_bit frozen, out_valid=1, no increment; resumes at s=4.
REQ-038 rst pulse at s=4 -> next cycle out_valid=0, s=START, a=8'h00, frame_cnt unchanged, no out_last; in_ready=1 after rst falls.
REQ-039 256 back-to-back bytes -> frame_cnt returns to 0.

Source files
------------

// File: rtl/serial_mux_sequencer.sv
// Byte serializer: latches a parallel byte into register a and walks a 3-bit
// select s across it, so out_bit is simply the 8:1 mux output a[s].
module serial_mux_sequencer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] a,
  output logic [2:0] s,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] frame_cnt
);

  localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] END_IDX   = MSB_FIRST ? 3'd0 : 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_a;
  logic [2:0] r_s;
  logic [7:0] r_frame_cnt;

  logic       w_in_acc;
  logic       w_out_acc;
  logic       w_at_end;

  // Handshake flags are gated by rst so nothing looks valid or ready while
  // reset is held, even before the first reset edge has cleared the state.
  assign out_valid = (r_state == SHIFT) & ~rst;
  assign w_at_end  = (r_s == END_IDX);
  assign out_last  = out_valid & w_at_end;
  assign in_ready  = ~rst & ((r_state == IDLE) | (out_last & out_ready));
  assign w_in_acc  = in_valid & in_ready;
  assign w_out_acc = out_valid & out_ready;

  // The mux itself: nothing but registered a indexed by registered s.
  assign out_bit   = r_a[r_s];

  assign a         = r_a;
  assign s         = r_s;
  assign frame_cnt = r_frame_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= 8'h00;
      r_s         <= START_IDX;
      r_frame_cnt <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_acc) begin
            r_a     <= in_data;
            r_s     <= START_IDX;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_out_acc) begin
            if (!w_at_end) begin
              r_s <= MSB_FIRST ? (r_s - 3'd1) : (r_s + 3'd1);
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
              // Zero-bubble reload when the next byte is taken with the last bit.
              if (w_in_acc) begin
                r_a <= in_data;
                r_s <= START_IDX;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
